approx_mult_rr_scheduler: RTL and testbench

//  Shares one combinational 8x8 unsigned approximate multiplier (l=6 family) among NREQ requesters.

---
 rtl/approx_mult_rr_scheduler.sv | 95 +++++++++
 tb/tb_approx_mult_rr_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_rr_scheduler.sv
// Round-robin front end sharing one external 8x8 approximate multiplier among NREQ lanes.
// Latency 2 cycles accept->rsp_valid; rsp_ready backpressure stalls B, then A, then deasserts req_ready.
module approx_mult_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  input  logic              cfg_exact,
  output logic [7:0]        mul_x,
  output logic [7:0]        mul_y,
  input  logic [15:0]       mul_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_z,
  output logic [CNTW-1:0]   txn_count
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic           a_v;
  logic [IDW-1:0] a_id;
  logic           a_exact;
  logic           stall_b;
  logic           stall_a;
  logic           accept;
  logic [15:0]    exact_z;
  int             idx;

  assign stall_b = rsp_valid & ~rsp_ready;
  assign stall_a = a_v & stall_b;

  // First valid requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  assign req_ready = (rst_n && !stall_a && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;
  assign accept    = |req_ready;
  assign exact_z   = {8'd0, mul_x} * {8'd0, mul_y};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      a_v       <= 1'b0;
      a_id      <= '0;
      a_exact   <= 1'b0;
      mul_x     <= '0;
      mul_y     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        a_v     <= 1'b1;
        a_id    <= gnt_idx;
        a_exact <= cfg_exact;
        mul_x   <= req_x[8*gnt_idx +: 8];
        mul_y   <= req_y[8*gnt_idx +: 8];
        if (!(&txn_count)) txn_count <= txn_count + CNTW'(1);
      end else if (!stall_a) begin
        a_v <= 1'b0;
      end

      // Stage A drains into B whenever B is free or being consumed this cycle.
      if (a_v && !stall_b) begin
        rsp_valid <= 1'b1;
        rsp_id    <= a_id;
        rsp_z     <= a_exact ? exact_z : mul_z;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_rr_scheduler.sv
// Directed bench for approx_mult_rr_scheduler with a response scoreboard and a truncating multiplier stub.
module tb_approx_mult_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_x, req_y;
  logic        cfg_exact;
  logic [7:0]  mul_x, mul_y;
  logic [15:0] mul_z;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_z;
  logic [15:0] txn_count;

  logic [3:0]  req_valid2, req_ready2;
  logic [31:0] req_x2, req_y2;
  logic [7:0]  mul_x2, mul_y2;
  logic [15:0] mul_z2;
  logic        rsp_valid2;
  logic [1:0]  rsp_id2;
  logic [15:0] rsp_z2;
  logic [3:0]  txn_count2;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  logic [17:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] stub(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = {8'd0, x} * {8'd0, y};
    if (x == 8'h12 && y == 8'h34) return 16'hA5A5;
    return p & 16'hFFC0;
  endfunction

  assign mul_z  = stub(mul_x, mul_y);
  assign mul_z2 = stub(mul_x2, mul_y2);

  approx_mult_rr_scheduler #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .cfg_exact(cfg_exact), .mul_x(mul_x), .mul_y(mul_y),
    .mul_z(mul_z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .txn_count(txn_count)
  );

  approx_mult_rr_scheduler #(.NREQ(4), .IDW(2), .CNTW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_x(req_x2), .req_y(req_y2),
    .req_ready(req_ready2), .cfg_exact(1'b1), .mul_x(mul_x2), .mul_y(mul_y2),
    .mul_z(mul_z2), .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_id(rsp_id2),
    .rsp_z(rsp_z2), .txn_count(txn_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on each response handshake, push on each accept.
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_rsp_id", 32'(rsp_id), 32'(e[17:16]));
          chk("sb_rsp_z", 32'(rsp_z), 32'(e[15:0]));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i])
          sb.push_back({2'(i), cfg_exact ? ({8'd0, req_x[8*i +: 8]} * {8'd0, req_y[8*i +: 8]})
                                         : stub(req_x[8*i +: 8], req_y[8*i +: 8])});
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; req_valid = 4'hF; req_x = '0; req_y = '0; cfg_exact = 1'b1; rsp_ready = 1'b1;
    req_valid2 = '0; req_x2 = '0; req_y2 = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    step(); step();
    rst_n = 1'b1; req_valid = '0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_txn_count", 32'(txn_count), 32'd0);
    chk("rst_mul_x", 32'(mul_x), 32'd0);

    // 1: single request, exact 255*255
    req_valid = 4'b0001; req_x[7:0] = 8'd255; req_y[7:0] = 8'd255; cfg_exact = 1'b1;
    @(negedge clk);
    chk("t1_req_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    chk("t1_txn_count", 32'(txn_count), 32'd1);
    chk("t1_rsp_valid_early", 32'(rsp_valid), 32'd0);
    step();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_z", 32'(rsp_z), 32'd65025);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    step();
    rst_n = 1'b0; step(); rst_n = 1'b1;

    // 2: all four requesting, approximate path, full rate
    cfg_exact = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_x[8*i +: 8] = 8'(10 + i);
      req_y[8*i +: 8] = 8'(20 + i);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) chk("t2_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) chk("t2_full_rate", 32'(rsp_valid), 32'd1);
      step();
      if (k == 7) req_valid = '0;
    end
    for (int n = 0; n < 50 && sb.size() != 0; n++) step();

    // 3: stub product vs exact product, flag captured at accept
    req_valid = 4'b0010; req_x[15:8] = 8'h12; req_y[15:8] = 8'h34; cfg_exact = 1'b0;
    step();
    req_valid = '0; cfg_exact = 1'b1;
    chk("t3_mul_x", 32'(mul_x), 32'h12);
    chk("t3_mul_y", 32'(mul_y), 32'h34);
    step();
    chk("t3_approx_z", 32'(rsp_z), 32'hA5A5);
    chk("t3_approx_id", 32'(rsp_id), 32'd1);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    chk("t3_exact_z", 32'(rsp_z), 32'h03A8);

    // 4: three requests, downstream stalls five cycles after the first response
    step();
    base = rsp_cnt;
    req_valid = 4'b1000; req_y[31:24] = 8'd5;
    for (int k = 0; k < 3; k++) begin
      req_x[31:24] = 8'(k + 1);
      @(negedge clk);
      chk("t4_grant", 32'(req_ready), 32'b1000);
      step();
    end
    req_valid = 4'b0001; req_x[7:0] = 8'd9; rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_stall_valid", 32'(rsp_valid), 32'd1);
      chk("t4_stall_z", 32'(rsp_z), 32'd10);
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int n = 0; n < 50 && sb.size() != 0; n++) step();
    step();
    chk("t4_rsp_count", 32'(rsp_cnt - base), 32'd3);

    // 5: reset with both stages full
    rsp_ready = 1'b0; req_valid = 4'b0001; req_x[7:0] = 8'd7; req_y[7:0] = 8'd7;
    step(); step();
    @(negedge clk);
    chk("t5_b_full", 32'(rsp_valid), 32'd1);
    chk("t5_a_stall", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0101;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_txn_count", 32'(txn_count), 32'd0);
    chk("t5_rsp_z", 32'(rsp_z), 32'd0);
    @(negedge clk);
    chk("t5_ptr0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0100; req_x[23:16] = 8'd3; req_y[23:16] = 8'd4;
    @(negedge clk);
    chk("t5_grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    step();
    chk("t5_rsp_id", 32'(rsp_id), 32'd2);
    chk("t5_rsp_z2", 32'(rsp_z), 32'd12);

    // 6: 4-bit counter saturates
    req_valid2 = 4'b0001; req_x2[7:0] = 8'd1; req_y2[7:0] = 8'd1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 13) chk("t6_count14", 32'(txn_count2), 32'd14);
    end
    req_valid2 = '0;
    chk("t6_count_sat", 32'(txn_count2), 32'd15);

    for (int n = 0; n < 50 && sb.size() != 0; n++) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
